fir_seq: RTL

Time-multiplexed, parametrised successor to the team's fully parallel 10-tap FIR. It computes a signed N-tap FIR on a streaming sample input with a single multiply-accumulate unit. Coefficients are runtime-loadable, and input and output use valid/ready handshakes. It sits between the sample source and downstream DSP stages wherever sample rate is at most clock/(N+1) and multiplier area matters.

---
 rtl/fir_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fir_seq.sv
// Time-multiplexed signed N-tap FIR: one multiply-accumulate per clock, runtime-loadable
// coefficients, valid/ready on input and output, rounded and saturated Q1.(W-1) result.
module fir_seq #(
   parameter int N     = 16,
   parameter int W     = 16,
   parameter int AW    = $clog2(N),
   parameter int ACC_W = 2*W + $clog2(N)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_sat,
   input  logic          coef_we,
   input  logic [AW-1:0] coef_addr,
   input  logic [W-1:0]  coef_data,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // Half an output LSB for round-half-up, and the representable output range.
   localparam logic signed [ACC_W-1:0] RND_C   = {{(ACC_W-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   state_t                   state_q, state_d;
   logic signed [W-1:0]      x_q [N];
   logic signed [W-1:0]      x_d [N];
   logic signed [W-1:0]      c_q [N];
   logic signed [W-1:0]      c_d [N];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [AW-1:0]            idx_q, idx_d;
   logic [W-1:0]             out_data_q, out_data_d;
   logic                     out_sat_q, out_sat_d;

   logic                     accept_s;
   logic                     last_s;
   logic                     coef_ok_s;
   logic [W-1:0]             tap_x_s;
   logic [W-1:0]             tap_c_s;
   logic [2*W-1:0]           prod_s;
   logic signed [ACC_W-1:0]  sum_s;
   logic signed [ACC_W-1:0]  rnd_sum_s;
   logic signed [ACC_W-1:0]  rnd_s;

   assign in_ready  = reset_n & ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
   assign accept_s  = in_valid & in_ready;
   assign out_valid = (state_q == S_HOLD);
   assign busy      = (state_q == S_RUN);
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

   assign last_s    = (idx_q == AW'(N-1));
   assign coef_ok_s = coef_we & (state_q != S_RUN) & ({1'b0, coef_addr} < (AW+1)'(N));
   assign tap_x_s   = x_q[idx_q];
   assign tap_c_s   = c_q[idx_q];
   // Low 2W bits of the sign-extended product equal the exact signed W x W product.
   assign prod_s    = {{W{tap_x_s[W-1]}}, tap_x_s} * {{W{tap_c_s[W-1]}}, tap_c_s};
   assign sum_s     = acc_q + {{(ACC_W-2*W){prod_s[2*W-1]}}, prod_s};
   assign rnd_sum_s = sum_s + RND_C;
   assign rnd_s     = rnd_sum_s >>> (W-1);

   // Next-state, datapath and output-register loading.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      c_d        = c_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;

      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            acc_d = sum_s;
            idx_d = idx_q + 1'b1;
            if (last_s) begin
               state_d = S_HOLD;
               if (rnd_s > OUT_MAX) begin
                  out_data_d = {1'b0, {(W-1){1'b1}}};
                  out_sat_d  = 1'b1;
               end else if (rnd_s < OUT_MIN) begin
                  out_data_d = {1'b1, {(W-1){1'b0}}};
                  out_sat_d  = 1'b1;
               end else begin
                  out_data_d = rnd_s[W-1:0];
                  out_sat_d  = 1'b0;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_HOLD: begin
            if (out_ready && in_valid) begin
               state_d = S_RUN;
            end else if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept_s) begin
         for (int k = N-1; k > 0; k--) begin
            x_d[k] = x_q[k-1];
         end
         x_d[0] = in_data;
         acc_d  = '0;
         idx_d  = '0;
      end else begin
         x_d = x_q;
      end

      // Writes are accepted outside RUN, including on the accept edge itself.
      if (coef_ok_s) begin
         c_d[coef_addr] = coef_data;
      end else begin
         c_d = c_q;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         for (int k = 0; k < N; k++) begin
            x_q[k] <= '0;
            c_q[k] <= '0;
         end
         acc_q      <= '0;
         idx_q      <= '0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         c_q        <= c_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
      end
   end

endmodule
